game_display_timing: RTL and testbench

- Generates raster timing for the game: clock-enable divider, horizontal/vertical counters, pixel coordinates for the sprite generators, and a frame-end strobe.
- Receives the mixer's registered rgb from the other end of the sprite → mixer → display path.
- Re-aligns hsync/vsync/blanking to the sprite+mixer pipeline latency and drives the VGA pins.

---
 rtl/game_display_pkg.sv | 32 +++
 rtl/game_config.svh | 7 +
 rtl/game_delay_line.sv | 47 ++++
 rtl/game_display_timing.sv | 151 +++++++++++++++
 tb/tb_game_display_timing.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_display_pkg.sv
// Default raster timing, sync polarity and the line/frame total helpers
// for the game display path.
package game_display_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_CLK_DIV      = 2;
  localparam int DEF_PIPE_LATENCY = 2;

  // VGA 640x480 uses negative sync pulses on both axes.
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = ~SYNC_ACTIVE;

  function automatic int calc_h_total(input int h_display, input int h_front,
                                      input int h_sync, input int h_back);
    return h_display + h_front + h_sync + h_back;
  endfunction

  function automatic int calc_v_total(input int v_display, input int v_front,
                                      input int v_sync, input int v_back);
    return v_display + v_front + v_sync + v_back;
  endfunction

endpackage

// File: rtl/game_config.svh
// Build-wide game configuration shared by the sprite, mixer and display blocks.
`ifndef GAME_CONFIG_SVH
`define GAME_CONFIG_SVH

`define GAME_RGB_WIDTH 3

`endif

// File: rtl/game_delay_line.sv
// Clock-rate shift register with a per-bit reset value; depth 0 is a wire.
module game_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 0) begin : g_bad_depth
    $error("game_delay_line: DEPTH must be non-negative");
  end

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/game_display_timing.sv
// Raster timing generator: pixel clock-enable, h/v counters, frame strobe,
// and VGA pin drive re-aligned to the sprite+mixer pipeline latency.
`include "game_config.svh"

module game_display_timing
  import game_display_pkg::*;
#(
  parameter int H_DISPLAY    = DEF_H_DISPLAY,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_DISPLAY    = DEF_V_DISPLAY,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       pixel_tick,
  output logic [X_WIDTH-1:0]         x,
  output logic [Y_WIDTH-1:0]         y,
  output logic                       display_on,
  output logic                       end_of_frame,
  input  logic [`GAME_RGB_WIDTH-1:0] rgb_in,
  output logic                       vga_hsync,
  output logic                       vga_vsync,
  output logic [`GAME_RGB_WIDTH-1:0] vga_rgb
);

  localparam int H_TOTAL = calc_h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [X_WIDTH-1:0] X_LAST       = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST       = Y_WIDTH'(V_TOTAL - 1);
  localparam logic [X_WIDTH-1:0] X_DISP       = X_WIDTH'(H_DISPLAY);
  localparam logic [Y_WIDTH-1:0] Y_DISP       = Y_WIDTH'(V_DISPLAY);
  localparam logic [X_WIDTH-1:0] X_SYNC_START = X_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [X_WIDTH-1:0] X_SYNC_END   = X_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [Y_WIDTH-1:0] Y_SYNC_START = Y_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [Y_WIDTH-1:0] Y_SYNC_END   = Y_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("game_display_timing: CLK_DIV must be at least 1");
  end
  if (PIPE_LATENCY < 0) begin : g_bad_lat
    $error("game_display_timing: PIPE_LATENCY must be non-negative");
  end
  if (H_TOTAL - 1 >= (1 << X_WIDTH)) begin : g_bad_xw
    $error("game_display_timing: H_TOTAL-1 does not fit in X_WIDTH");
  end
  if (V_TOTAL - 1 >= (1 << Y_WIDTH)) begin : g_bad_yw
    $error("game_display_timing: V_TOTAL-1 does not fit in Y_WIDTH");
  end

  logic [DIV_W-1:0]           div_cnt_q, div_cnt_d;
  logic [X_WIDTH-1:0]         x_q, x_d;
  logic [Y_WIDTH-1:0]         y_q, y_d;
  logic                       vga_hsync_q, vga_hsync_d;
  logic                       vga_vsync_q, vga_vsync_d;
  logic [`GAME_RGB_WIDTH-1:0] vga_rgb_q, vga_rgb_d;

  logic       hs_raw, vs_raw;
  logic [2:0] align_in, align_out;
  logic       hs_al, vs_al, de_al;

  // With CLK_DIV=1 the divider is pinned at 0 == DIV_LAST, so the tick is constant.
  always_comb begin
    pixel_tick = (div_cnt_q == DIV_LAST);
    div_cnt_d  = pixel_tick ? '0 : div_cnt_q + 1'b1;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pixel_tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  always_comb begin
    display_on   = (x_q < X_DISP) && (y_q < Y_DISP);
    end_of_frame = pixel_tick && (x_q == X_LAST) && (y_q == Y_LAST);
    hs_raw       = ((x_q >= X_SYNC_START) && (x_q < X_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
    vs_raw       = ((y_q >= Y_SYNC_START) && (y_q < Y_SYNC_END)) ? SYNC_ACTIVE : SYNC_IDLE;
  end

  assign x = x_q;
  assign y = y_q;

  // Runs every clk so the control bits track the mixer's clk-rate pipeline.
  assign align_in = {hs_raw, vs_raw, display_on};

  game_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_LATENCY),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (align_in),
    .dout (align_out)
  );

  assign {hs_al, vs_al, de_al} = align_out;

  always_comb begin
    vga_hsync_d = hs_al;
    vga_vsync_d = vs_al;
    vga_rgb_d   = de_al ? rgb_in : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hsync_q <= SYNC_IDLE;
      vga_vsync_q <= SYNC_IDLE;
      vga_rgb_q   <= '0;
    end else begin
      vga_hsync_q <= vga_hsync_d;
      vga_vsync_q <= vga_vsync_d;
      vga_rgb_q   <= vga_rgb_d;
    end
  end

  assign vga_hsync = vga_hsync_q;
  assign vga_vsync = vga_vsync_q;
  assign vga_rgb   = vga_rgb_q;

endmodule

// File: tb/tb_game_display_timing.sv
// Bench for game_display_timing on a shrunken 14x7 raster with a pin scoreboard.
`include "game_config.svh"

module tb_game_display_timing;

  localparam int HD = 8, HF = 2, HS = 2, HB = 2;
  localparam int VD = 4, VF = 1, VS = 1, VB = 1;
  localparam int DIV = 2, LAT = 2;
  localparam int HT = 14, VT = 7;
  localparam int FRAME = HT * VT * DIV;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [`GAME_RGB_WIDTH-1:0] rgb_in = '0;
  logic                       pixel_tick, display_on, end_of_frame;
  logic [9:0]                 x, y;
  logic                       vga_hsync, vga_vsync;
  logic [`GAME_RGB_WIDTH-1:0] vga_rgb;

  game_display_timing #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .PIPE_LATENCY(LAT), .X_WIDTH(10), .Y_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .x(x), .y(y),
    .display_on(display_on), .end_of_frame(end_of_frame), .rgb_in(rgb_in),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  // n = number of rising edges since reset release
  int n;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  typedef struct {
    int         cyc;
    logic [4:0] pins;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  wire [4:0]  pins_obs = {vga_hsync, vga_vsync, vga_rgb};
  wire [22:0] cnt_obs  = {x, y, pixel_tick, display_on, end_of_frame};

  function automatic int mx(input int k); return (k / DIV) % HT; endfunction
  function automatic int my(input int k); return (k / DIV / HT) % VT; endfunction
  function automatic logic m_tick(input int k); return (k % DIV) == DIV - 1; endfunction
  function automatic logic m_de(input int k); return (mx(k) < HD) && (my(k) < VD); endfunction
  function automatic logic m_hs(input int k);
    return !((mx(k) >= HD + HF) && (mx(k) < HD + HF + HS));
  endfunction
  function automatic logic m_vs(input int k);
    return !((my(k) >= VD + VF) && (my(k) < VD + VF + VS));
  endfunction
  function automatic logic [22:0] exp_cnt(input int k);
    logic eof;
    eof = m_tick(k) && (mx(k) == HT - 1) && (my(k) == VT - 1);
    return {10'(mx(k)), 10'(my(k)), m_tick(k), m_de(k), eof};
  endfunction

  // Drive rgb_in for the current cycle and book what the pins must show one clk later.
  task automatic drive_cycle(input logic [2:0] r);
    exp_t e;
    rgb_in = r;
    e.cyc = n + 1;
    if (n >= LAT) e.pins = {m_hs(n - LAT), m_vs(n - LAT), m_de(n - LAT) ? r : 3'b000};
    else          e.pins = 5'b11000;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    rgb_in = 3'b111;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_obs, pins_obs} !== {23'b0000000000_0000000000_0_1_0, 5'b11000}) begin
      errors++;
      $display("FAIL reset_values got cnt=%h pins=%b exp cnt=%h pins=%b",
               cnt_obs, pins_obs, 23'b0000000000_0000000000_0_1_0, 5'b11000);
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (pixel_tick !== 1'b0 || x !== 10'd0) begin
      errors++;
      $display("FAIL release_cycle0 got tick=%b x=%0d exp tick=0 x=0", pixel_tick, x);
    end
    drive_cycle(3'b000);
    @(negedge clk);
    checks++;
    if (pixel_tick !== 1'b1 || x !== 10'd0) begin
      errors++;
      $display("FAIL first_tick got tick=%b x=%0d exp tick=1 x=0", pixel_tick, x);
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
      e = exp_q.pop_front();
      checks++;
      if (pins_obs !== e.pins) begin
        errors++;
        $display("FAIL reset_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
      end
    end
    drive_cycle(3'b000);
    @(negedge clk);
    checks++;
    if (pixel_tick !== 1'b0 || x !== 10'd1) begin
      errors++;
      $display("FAIL x_after_tick got tick=%b x=%0d exp tick=0 x=1", pixel_tick, x);
    end
    drive_cycle(3'b000);
  endtask

  task automatic test_line();
    exp_t e;
    for (int i = 0; i < 2 * HT * DIV; i++) begin
      @(negedge clk);
      checks++;
      if (cnt_obs !== exp_cnt(n)) begin
        errors++;
        $display("FAIL line_counters n=%0d got=%h exp=%h", n, cnt_obs, exp_cnt(n));
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL line_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      drive_cycle(3'b000);
    end
  endtask

  task automatic test_frame();
    exp_t e;
    int eof_n[$];
    for (int i = 0; i < 3 * FRAME && eof_n.size() < 2; i++) begin
      @(negedge clk);
      checks++;
      if (cnt_obs !== exp_cnt(n)) begin
        errors++;
        $display("FAIL frame_counters n=%0d got=%h exp=%h", n, cnt_obs, exp_cnt(n));
      end
      if (end_of_frame === 1'b1) eof_n.push_back(n);
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL frame_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      drive_cycle(3'b000);
    end
    checks++;
    if (eof_n.size() < 2) begin
      errors++;
      $display("FAIL frame_timeout got %0d end_of_frame pulses exp 2", eof_n.size());
    end else if (eof_n[1] - eof_n[0] != FRAME) begin
      errors++;
      $display("FAIL frame_period got=%0d exp=%0d", eof_n[1] - eof_n[0], FRAME);
    end
  endtask

  task automatic test_sync();
    exp_t e;
    int hs_low = 0, vs_low = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (vga_hsync === 1'b0) hs_low++;
      if (vga_vsync === 1'b0) vs_low++;
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL sync_pins n=%0d x_al=%0d y_al=%0d got=%b exp=%b",
                   n, mx(n - LAT - 1), my(n - LAT - 1), pins_obs, e.pins);
        end
      end
      drive_cycle(3'b000);
    end
    checks++;
    if (hs_low != HS * DIV * VT || vs_low != VS * HT * DIV) begin
      errors++;
      $display("FAIL sync_widths got hs_low=%0d vs_low=%0d exp %0d %0d",
               hs_low, vs_low, HS * DIV * VT, VS * HT * DIV);
    end
  endtask

  task automatic test_alignment();
    exp_t e;
    int hits = 0, stray = 0;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      if (i > 0 && vga_rgb === 3'b101) hits++;
      if (i > 0 && vga_rgb !== 3'b101 && vga_rgb !== 3'b000) stray++;
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL align_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      drive_cycle((mx(n - LAT) == 3 && my(n - LAT) == 1) ? 3'b101 : 3'b000);
    end
    checks++;
    if (hits != DIV || stray != 0) begin
      errors++;
      $display("FAIL align_count got hits=%0d stray=%0d exp hits=%0d stray=0", hits, stray, DIV);
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    int lit = 0;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      if (i > 0 && vga_rgb !== 3'b000) lit++;
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL blank_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      drive_cycle(3'b111);
    end
    checks++;
    if (lit != HD * VD * DIV) begin
      errors++;
      $display("FAIL blank_count got=%0d exp=%0d", lit, HD * VD * DIV);
    end
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL pre_reset_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      if (x === 10'd5 && y === 10'd2) found = 1;
      else drive_cycle(3'b111);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_timeout got no x=5 y=2 exp it within %0d clk", 2 * FRAME);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cnt_obs, pins_obs} !== {23'b0000000000_0000000000_0_1_0, 5'b11000}) begin
      errors++;
      $display("FAIL midreset_values got cnt=%h pins=%b exp cnt=%h pins=%b",
               cnt_obs, pins_obs, 23'b0000000000_0000000000_0_1_0, 5'b11000);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_cycle(3'b111);
    for (int i = 0; i < 3 * HT; i++) begin
      @(negedge clk);
      checks++;
      if (cnt_obs !== exp_cnt(n)) begin
        errors++;
        $display("FAIL restart_counters n=%0d got=%h exp=%h", n, cnt_obs, exp_cnt(n));
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        checks++;
        if (pins_obs !== e.pins) begin
          errors++;
          $display("FAIL restart_pins n=%0d got=%b exp=%b", n, pins_obs, e.pins);
        end
      end
      drive_cycle(3'b111);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_sync();
    test_alignment();
    test_blanking();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
